// File: rtl/usb3_fifo_reader.sv
// FX3 slave-FIFO read master: waits for FLAGA, reads one BURST_LEN-word burst and tags each word with code 6.
// Outputs are registered from next_state, so a state's strobes are live on the cycle it is entered.
module usb3_fifo_reader #(
  parameter int         BURST_LEN  = 256,
  parameter int         RD_LATENCY = 2,
  parameter int         HOLDOFF    = 4,
  parameter logic [1:0] FIFO_ADDR  = 2'b11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        USB3_FLAGA,
  input  logic [31:0] USB3_DQ,
  output logic        USB3_SLCS_N,
  output logic        USB3_SLOE_N,
  output logic        USB3_SLRD_N,
  output logic        USB3_SLWR_N,
  output logic [1:0]  USB3_A,
  output logic [31:0] data,
  output logic [3:0]  usb_rd_state,
  output logic        burst_done,
  output logic [15:0] burst_count
);

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_SEL   = 4'd1,
    S_OE    = 4'd2,
    S_RD    = 4'd3,
    S_FILL  = 4'd4,
    S_FILL2 = 4'd5,
    S_DATA  = 4'd6,
    S_END   = 4'd7,
    S_HOLD  = 4'd8
  } state_t;

  localparam logic [16:0] ISSUE_MAX = 17'(BURST_LEN);
  localparam logic [15:0] CAP_LAST  = 16'(BURST_LEN - 1);
  localparam logic [2:0]  LAT_LAST  = 3'(RD_LATENCY - 1);
  localparam logic [3:0]  HOLD_LAST = 4'(HOLDOFF - 1);

  state_t      state, next_state;
  logic [16:0] issue_cnt, issue_nxt;
  logic [15:0] cap_cnt;
  logic [2:0]  lat_cnt;
  logic [3:0]  hold_cnt;
  logic        cs_nxt, oe_nxt, rd_nxt;

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: if (en && USB3_FLAGA) next_state = S_SEL;
      S_SEL:  next_state = S_OE;
      S_OE:   next_state = S_RD;
      S_RD, S_FILL, S_FILL2: begin
        if (lat_cnt == LAT_LAST)  next_state = S_DATA;
        else if (state == S_FILL) next_state = S_FILL2;
        else                      next_state = S_FILL;
      end
      S_DATA: if (cap_cnt == CAP_LAST) next_state = S_END;
      S_END:  next_state = S_HOLD;
      S_HOLD: if (hold_cnt == HOLD_LAST) next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // The read strobe is cut by issued count, not by state, so the pipeline drains in DATA with SLRD_N high.
  always_comb begin
    issue_nxt = issue_cnt + {16'd0, ~USB3_SLRD_N};
    cs_nxt    = next_state inside {S_SEL, S_OE, S_RD, S_FILL, S_FILL2, S_DATA};
    oe_nxt    = next_state inside {S_OE, S_RD, S_FILL, S_FILL2, S_DATA};
    rd_nxt    = (next_state inside {S_RD, S_FILL, S_FILL2, S_DATA}) && (issue_nxt < ISSUE_MAX);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      issue_cnt   <= '0;
      cap_cnt     <= '0;
      lat_cnt     <= '0;
      hold_cnt    <= '0;
      USB3_SLCS_N <= 1'b1;
      USB3_SLOE_N <= 1'b1;
      USB3_SLRD_N <= 1'b1;
      USB3_A      <= 2'b00;
      data        <= '0;
      burst_done  <= 1'b0;
      burst_count <= '0;
    end else begin
      state       <= next_state;
      issue_cnt   <= (state == S_IDLE) ? 17'd0 : issue_nxt;
      cap_cnt     <= (state == S_DATA) ? cap_cnt + 16'd1 : 16'd0;
      lat_cnt     <= (state inside {S_RD, S_FILL, S_FILL2}) ? lat_cnt + 3'd1 : 3'd0;
      hold_cnt    <= (state == S_HOLD) ? hold_cnt + 4'd1 : 4'd0;
      USB3_SLCS_N <= ~cs_nxt;
      USB3_SLOE_N <= ~oe_nxt;
      USB3_SLRD_N <= ~rd_nxt;
      USB3_A      <= cs_nxt ? FIFO_ADDR : 2'b00;
      if (next_state == S_DATA) data <= USB3_DQ;
      burst_done  <= (next_state == S_END);
      if (next_state == S_END) burst_count <= burst_count + 16'd1;
    end
  end

  assign usb_rd_state = state;
  assign USB3_SLWR_N  = 1'b1;

endmodule
